// File: rtl/ev_bms_vlsi.sv
// 3-cell EV pack protection controller: threshold flags, FET enable FSM, SOH wear counter.
// Latency 2 edges input->output; no backpressure, every cycle is sampled.
module ev_bms_vlsi #(
   parameter logic [11:0] OV_TH        = 12'd4000,
   parameter logic [11:0] UV_TH        = 12'd3000,
   parameter logic [11:0] OC_TH        = 12'd3000,
   parameter logic [11:0] OT_TH        = 12'd800,
   parameter logic [7:0]  SOC_LOW      = 8'd5,
   parameter logic [7:0]  SOC_HIGH     = 8'd95,
   parameter logic [7:0]  SOH_INIT     = 8'd100,
   parameter logic [7:0]  SOH_MIN      = 8'd70,
   parameter int unsigned CLEAR_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] cell_1_voltage_adc,
   input  logic [11:0] cell_2_voltage_adc,
   input  logic [11:0] cell_3_voltage_adc,
   input  logic [11:0] pack_current_adc,
   input  logic [11:0] temperature_adc,
   input  logic [7:0]  soc_percent,
   output logic        charge_en_fsm,
   output logic        discharge_en_fsm,
   output logic        system_fault,
   output logic [7:0]  soh_percent,
   output logic        soh_fault
);

   localparam int CW = $clog2(CLEAR_CYCLES + 2);
   localparam logic [CW-1:0] LP_CLEAR = CW'(CLEAR_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      NORMAL  = 2'd1,
      FAULT   = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_fault_q;
   logic          r_soc_low_q;
   logic          r_soc_high_q;

   logic          w_ov;
   logic          w_uv;
   logic          w_oc;
   logic          w_ot;
   logic [7:0]    w_soc;
   logic [7:0]    w_soh_dec;
   logic [CW-1:0] w_cnt_inc;

   assign w_ov = (cell_1_voltage_adc > OV_TH) || (cell_2_voltage_adc > OV_TH) ||
                 (cell_3_voltage_adc > OV_TH);
   assign w_uv = (cell_1_voltage_adc < UV_TH) || (cell_2_voltage_adc < UV_TH) ||
                 (cell_3_voltage_adc < UV_TH);
   assign w_oc = pack_current_adc > OC_TH;
   assign w_ot = temperature_adc > OT_TH;
   // SOC codes above 100 come from a misbehaving estimator; treat them as full.
   assign w_soc = (soc_percent > 8'd100) ? 8'd100 : soc_percent;

   assign w_soh_dec = (soh_percent == 8'd0) ? 8'd0 : soh_percent - 8'd1;
   assign w_cnt_inc = r_cnt + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_q    <= 1'b0;
         r_soc_low_q  <= 1'b0;
         r_soc_high_q <= 1'b0;
      end else begin
         r_fault_q    <= w_ov | w_uv | w_oc | w_ot;
         r_soc_low_q  <= w_soc < SOC_LOW;
         r_soc_high_q <= w_soc > SOC_HIGH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         charge_en_fsm    <= 1'b0;
         discharge_en_fsm <= 1'b0;
         system_fault     <= 1'b0;
         soh_percent      <= SOH_INIT;
         soh_fault        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Entry from IDLE is not wear, so SOH is left alone here.
               if (r_fault_q) begin
                  r_state          <= FAULT;
                  charge_en_fsm    <= 1'b0;
                  discharge_en_fsm <= 1'b0;
                  system_fault     <= 1'b1;
               end else begin
                  r_state          <= NORMAL;
                  charge_en_fsm    <= ~r_soc_high_q;
                  discharge_en_fsm <= ~r_soc_low_q;
                  system_fault     <= 1'b0;
               end
            end
            NORMAL: begin
               if (r_fault_q) begin
                  r_state          <= FAULT;
                  charge_en_fsm    <= 1'b0;
                  discharge_en_fsm <= 1'b0;
                  system_fault     <= 1'b1;
                  soh_percent      <= w_soh_dec;
                  soh_fault        <= w_soh_dec < SOH_MIN;
               end else begin
                  charge_en_fsm    <= ~r_soc_high_q;
                  discharge_en_fsm <= ~r_soc_low_q;
                  system_fault     <= 1'b0;
               end
            end
            FAULT: begin
               charge_en_fsm    <= 1'b0;
               discharge_en_fsm <= 1'b0;
               system_fault     <= 1'b1;
               if (!r_fault_q) begin
                  r_state <= RECOVER;
                  r_cnt   <= CW'(1);
               end
            end
            RECOVER: begin
               if (r_fault_q) begin
                  r_state          <= FAULT;
                  r_cnt            <= '0;
                  charge_en_fsm    <= 1'b0;
                  discharge_en_fsm <= 1'b0;
                  system_fault     <= 1'b1;
                  soh_percent      <= w_soh_dec;
                  soh_fault        <= w_soh_dec < SOH_MIN;
               end else if (w_cnt_inc >= LP_CLEAR) begin
                  r_state          <= NORMAL;
                  r_cnt            <= '0;
                  charge_en_fsm    <= ~r_soc_high_q;
                  discharge_en_fsm <= ~r_soc_low_q;
                  system_fault     <= 1'b0;
               end else begin
                  r_cnt            <= w_cnt_inc;
                  charge_en_fsm    <= 1'b0;
                  discharge_en_fsm <= 1'b0;
                  system_fault     <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ev_bms_vlsi.sv
// Directed bench for ev_bms_vlsi: thresholds, FSM recovery timing, SOC gating, SOH wear and reset.
module tb_ev_bms_vlsi;

   logic        clk;
   logic        rst_n;
   logic [11:0] c1, c2, c3, cur, tmp;
   logic [7:0]  soc;
   logic        chg, dis, sf, soh_f;
   logic [7:0]  soh;

   int tests = 0;
   int fails = 0;

   ev_bms_vlsi dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cell_1_voltage_adc(c1),
      .cell_2_voltage_adc(c2),
      .cell_3_voltage_adc(c3),
      .pack_current_adc  (cur),
      .temperature_adc   (tmp),
      .soc_percent       (soc),
      .charge_en_fsm     (chg),
      .discharge_en_fsm  (dis),
      .system_fault      (sf),
      .soh_percent       (soh),
      .soh_fault         (soh_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_nominal();
      c1 = 12'd3600; c2 = 12'd3550; c3 = 12'd3580;
      cur = 12'd100; tmp = 12'd500; soc = 8'd50;
   endtask

   task automatic test_reset();
      set_nominal();
      rst_n = 1'b0;
      #12;
      tests++;
      if ({chg, dis, sf, soh_f} !== 4'b0000 || soh !== 8'd100) begin
         fails++;
         $display("FAIL reset: got ch/dis/sf/sohf=%b soh=%0d, want 0000 soh=100", {chg, dis, sf, soh_f}, soh);
      end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_normal();
      step(2);
      tests++;
      if ({chg, dis, sf, soh_f} !== 4'b1100 || soh !== 8'd100) begin
         fails++;
         $display("FAIL normal: got %b soh=%0d, want 1100 soh=100", {chg, dis, sf, soh_f}, soh);
      end
   endtask

   task automatic test_fault_entry();
      c1 = 12'd4095;
      step(2);
      tests++;
      if ({chg, dis, sf} !== 3'b001 || soh !== 8'd99) begin
         fails++;
         $display("FAIL ov_entry: got %b soh=%0d, want 001 soh=99", {chg, dis, sf}, soh);
      end
      c1 = 12'd2500;
      step(3);
      tests++;
      if ({chg, dis, sf} !== 3'b001 || soh !== 8'd99) begin
         fails++;
         $display("FAIL uv_hold: got %b soh=%0d, want 001 soh=99", {chg, dis, sf}, soh);
      end
   endtask

   task automatic test_recover();
      c1 = 12'd3600; tmp = 12'd900;
      step(3);
      tests++;
      if (sf !== 1'b1 || soh !== 8'd99) begin
         fails++;
         $display("FAIL ot_hold: got sf=%b soh=%0d, want sf=1 soh=99", sf, soh);
      end
      tmp = 12'd500;
      step(4);
      tests++;
      if ({chg, dis, sf} !== 3'b001) begin
         fails++;
         $display("FAIL recover_hold: got %b, want 001", {chg, dis, sf});
      end
      step(1);
      tests++;
      if ({chg, dis, sf} !== 3'b110 || soh !== 8'd99) begin
         fails++;
         $display("FAIL recover_exit: got %b soh=%0d, want 110 soh=99", {chg, dis, sf}, soh);
      end
      tmp = 12'd900;
      step(2);
      tmp = 12'd500;
      step(2);
      tests++;
      if (sf !== 1'b1 || soh !== 8'd98) begin
         fails++;
         $display("FAIL in_recover: got sf=%b soh=%0d, want sf=1 soh=98", sf, soh);
      end
      tmp = 12'd900;
      step(2);
      tests++;
      if ({chg, dis, sf} !== 3'b001 || soh !== 8'd97) begin
         fails++;
         $display("FAIL refault: got %b soh=%0d, want 001 soh=97", {chg, dis, sf}, soh);
      end
      tmp = 12'd500;
      step(5);
      tests++;
      if ({chg, dis, sf} !== 3'b110) begin
         fails++;
         $display("FAIL refault_clear: got %b, want 110", {chg, dis, sf});
      end
   endtask

   task automatic test_soc();
      logic [7:0] soc_v [5] = '{8'd4, 8'd98, 8'd5, 8'd95, 8'd200};
      logic [1:0] exp_v [5] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b01};
      for (int i = 0; i < 5; i++) begin
         soc = soc_v[i];
         step(2);
         tests++;
         if ({chg, dis} !== exp_v[i] || sf !== 1'b0) begin
            fails++;
            $display("FAIL soc_%0d: got ch/dis=%b sf=%b, want %b sf=0", soc_v[i], {chg, dis}, sf, exp_v[i]);
         end
      end
      soc = 8'd50;
      step(2);
   endtask

   task automatic test_boundaries();
      // Each entry: which input (0..4 = c1,c2,c3,cur,tmp), value, expected fault.
      int         sel_v [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
      logic [11:0] val_v [10] = '{12'd4000, 12'd3000, 12'd4000, 12'd3000, 12'd800,
                                  12'd4001, 12'd2999, 12'd4001, 12'd3001, 12'd801};
      logic        flt_v [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      for (int i = 0; i < 10; i++) begin
         set_nominal();
         case (sel_v[i])
            0: c1 = val_v[i];
            1: c2 = val_v[i];
            2: c3 = val_v[i];
            3: cur = val_v[i];
            default: tmp = val_v[i];
         endcase
         step(2);
         tests++;
         if (sf !== flt_v[i]) begin
            fails++;
            $display("FAIL bound_%0d_%0d: got sf=%b, want %b", sel_v[i], val_v[i], sf, flt_v[i]);
         end
         set_nominal();
         step(5);
      end
      tests++;
      if (soh !== 8'd92 || sf !== 1'b0) begin
         fails++;
         $display("FAIL bound_soh: got soh=%0d sf=%b, want 92 sf=0", soh, sf);
      end
      c1 = 12'd4095; tmp = 12'd900; cur = 12'd3500;
      step(2);
      set_nominal();
      step(5);
      tests++;
      if (soh !== 8'd91) begin
         fails++;
         $display("FAIL multi_source: got soh=%0d, want 91", soh);
      end
   endtask

   task automatic test_soh_wear();
      int exp_soh = 91;
      while (exp_soh > 0) begin
         tmp = 12'd900;
         step(2);
         exp_soh--;
         tmp = 12'd500;
         step(5);
         if (exp_soh == 70 || exp_soh == 69) begin
            tests++;
            if (soh !== 8'(exp_soh) || soh_f !== (exp_soh < 70)) begin
               fails++;
               $display("FAIL soh_%0d: got soh=%0d sohf=%b", exp_soh, soh, soh_f);
            end
         end
      end
      tmp = 12'd900;
      step(2);
      tests++;
      if (soh !== 8'd0 || soh_f !== 1'b1 || sf !== 1'b1) begin
         fails++;
         $display("FAIL soh_sat: got soh=%0d sohf=%b sf=%b, want 0 1 1", soh, soh_f, sf);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({chg, dis, sf, soh_f} !== 4'b0000 || soh !== 8'd100) begin
         fails++;
         $display("FAIL mid_reset: got %b soh=%0d, want 0000 soh=100", {chg, dis, sf, soh_f}, soh);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_fault_entry();
      test_recover();
      test_soc();
      test_boundaries();
      test_soh_wear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
